// File: rtl/aurora_nfc_ctrl.sv
// Aurora native flow control scheduler: turns RX FIFO watermark status into
// XOFF/XON requests on the core's NFC AXI-S port, refreshing XOFF while paused.
module aurora_nfc_ctrl #(
    parameter logic [7:0] PAUSE_LEN      = 8'hFF,
    parameter int          REFRESH_PERIOD = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_ready,
    input  logic        fifo_below_lwm,
    input  logic        fifo_above_hwm,
    output logic        nfc_tvalid,
    output logic [15:0] nfc_tdata,
    input  logic        nfc_tready,
    output logic        paused,
    output logic [15:0] xoff_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ_XOFF = 2'd1,
        PAUSED   = 2'd2,
        REQ_XON  = 2'd3
    } state_t;

    localparam logic [15:0] XOFF_WORD    = {PAUSE_LEN, 7'b0000000, 1'b1};
    localparam logic [15:0] XON_WORD     = 16'h0000;
    localparam logic [15:0] REFRESH_LOAD = 16'(REFRESH_PERIOD - 1);

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [15:0] timer_r;
    logic [15:0] timer_next_s;
    logic [15:0] count_r;
    logic [15:0] count_next_s;
    logic        tvalid_r;
    logic        tvalid_next_s;
    logic [15:0] tdata_r;
    logic [15:0] tdata_next_s;
    logic        paused_r;
    logic        paused_next_s;
    logic        handshake_s;

    assign handshake_s = tvalid_r & nfc_tready;

    // Next-state, refresh timer and saturating XOFF counter.
    always_comb begin
        state_next_s = state_r;
        timer_next_s = timer_r;
        count_next_s = count_r;
        case (state_r)
            IDLE: begin
                if (fifo_ready && fifo_above_hwm) begin
                    state_next_s = REQ_XOFF;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ_XOFF: begin
                if (handshake_s) begin
                    state_next_s = PAUSED;
                    timer_next_s = REFRESH_LOAD;
                    count_next_s = sat_inc16(count_r);
                end else begin
                    state_next_s = REQ_XOFF;
                end
            end
            PAUSED: begin
                if (timer_r != 16'd0) begin
                    timer_next_s = timer_r - 16'd1;
                end else begin
                    timer_next_s = timer_r;
                end
                // Resuming takes precedence over a due refresh.
                if (!fifo_ready || fifo_below_lwm) begin
                    state_next_s = REQ_XON;
                end else if (timer_r == 16'd0) begin
                    state_next_s = REQ_XOFF;
                end else begin
                    state_next_s = PAUSED;
                end
            end
            REQ_XON: begin
                if (handshake_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = REQ_XON;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so every port leaves a flop.
    always_comb begin
        tvalid_next_s = 1'b0;
        tdata_next_s  = XON_WORD;
        paused_next_s = 1'b0;
        case (state_next_s)
            IDLE: begin
                tvalid_next_s = 1'b0;
                paused_next_s = 1'b0;
            end
            REQ_XOFF: begin
                tvalid_next_s = 1'b1;
                tdata_next_s  = XOFF_WORD;
                paused_next_s = paused_r;
            end
            PAUSED: begin
                tvalid_next_s = 1'b0;
                paused_next_s = 1'b1;
            end
            REQ_XON: begin
                tvalid_next_s = 1'b1;
                tdata_next_s  = XON_WORD;
                paused_next_s = 1'b1;
            end
            default: begin
                tvalid_next_s = 1'b0;
                paused_next_s = 1'b0;
            end
        endcase
    end

    // State, timer, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            timer_r  <= 16'd0;
            count_r  <= 16'd0;
            tvalid_r <= 1'b0;
            tdata_r  <= 16'h0000;
            paused_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            timer_r  <= timer_next_s;
            count_r  <= count_next_s;
            tvalid_r <= tvalid_next_s;
            tdata_r  <= tdata_next_s;
            paused_r <= paused_next_s;
        end
    end

    assign nfc_tvalid = tvalid_r;
    assign nfc_tdata  = tdata_r;
    assign paused     = paused_r;
    assign xoff_count = count_r;

endmodule

// File: tb/tb_aurora_nfc_ctrl.sv
// Self-checking bench for aurora_nfc_ctrl: scoreboarded NFC words on the main
// instance, plus refresh (period 5) and saturation (period 1) instances.
module tb_aurora_nfc_ctrl;

    localparam logic [15:0] XOFF_W = 16'hFF01;
    localparam logic [15:0] XON_W  = 16'h0000;

    int checks   = 0;
    int failures = 0;

    logic clk   = 1'b0;
    logic clk_s = 1'b0;
    always #5 clk = ~clk;
    always #1 clk_s = ~clk_s;

    logic        rst = 1'b1;
    logic        ready = 1'b0, below = 1'b0, above = 1'b0, tready = 1'b0;
    logic        tvalid, paused;
    logic [15:0] tdata, xoff_count;

    logic        r_ready = 1'b0, r_below = 1'b0, r_above = 1'b0, r_tready = 1'b0;
    logic        r_tvalid, r_paused;
    logic [15:0] r_tdata, r_xoff_count;

    logic        s_rst = 1'b1;
    logic        s_ready = 1'b0, s_below = 1'b0, s_above = 1'b0, s_tready = 1'b0;
    logic        s_tvalid, s_paused;
    logic [15:0] s_tdata, s_xoff_count;
    int          s_hs = 0;

    logic [15:0] exp_q[$];

    aurora_nfc_ctrl dut (
        .clk(clk), .rst(rst), .fifo_ready(ready), .fifo_below_lwm(below),
        .fifo_above_hwm(above), .nfc_tvalid(tvalid), .nfc_tdata(tdata),
        .nfc_tready(tready), .paused(paused), .xoff_count(xoff_count)
    );

    aurora_nfc_ctrl #(.REFRESH_PERIOD(5)) dut_r (
        .clk(clk), .rst(rst), .fifo_ready(r_ready), .fifo_below_lwm(r_below),
        .fifo_above_hwm(r_above), .nfc_tvalid(r_tvalid), .nfc_tdata(r_tdata),
        .nfc_tready(r_tready), .paused(r_paused), .xoff_count(r_xoff_count)
    );

    aurora_nfc_ctrl #(.REFRESH_PERIOD(1)) dut_s (
        .clk(clk_s), .rst(s_rst), .fifo_ready(s_ready), .fifo_below_lwm(s_below),
        .fifo_above_hwm(s_above), .nfc_tvalid(s_tvalid), .nfc_tdata(s_tdata),
        .nfc_tready(s_tready), .paused(s_paused), .xoff_count(s_xoff_count)
    );

    // Scoreboard: every accepted NFC word on the main instance must match the queue head.
    always @(posedge clk) begin
        if (!rst && tvalid && tready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got=%h required=none", tdata);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (tdata !== e) begin
                    failures++;
                    $display("FAIL sb_word got=%h required=%h", tdata, e);
                end
            end
        end
    end

    // Handshake counter for the saturation instance.
    always @(posedge clk_s) begin
        if (!s_rst && s_tvalid && s_tready) s_hs++;
    end

    // The saturation instance free-runs from time zero with XOFF refreshes every two cycles.
    initial begin
        repeat (3) @(negedge clk_s);
        s_rst = 1'b0; s_ready = 1'b1; s_above = 1'b1; s_tready = 1'b1;
    end

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({tvalid, tdata, paused, xoff_count} !== 34'd0) begin
            failures++;
            $display("FAIL reset_main got=%b/%h/%b/%h required=0/0000/0/0000", tvalid, tdata, paused, xoff_count);
        end
        checks++;
        if ({r_tvalid, r_tdata, r_paused, r_xoff_count} !== 34'd0) begin
            failures++;
            $display("FAIL reset_refresh got=%b/%h/%b/%h required=0/0000/0/0000", r_tvalid, r_tdata, r_paused, r_xoff_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int hi = 0;
        ready = 1'b1; tready = 1'b1; above = 1'b1; exp_q.push_back(XOFF_W);
        @(negedge clk);
        checks++;
        if (tvalid !== 1'b1 || tdata !== XOFF_W || paused !== 1'b0) begin
            failures++;
            $display("FAIL basic_xoff got=%b/%h/%b required=1/ff01/0", tvalid, tdata, paused);
        end
        @(negedge clk);
        checks++;
        if (tvalid !== 1'b0 || paused !== 1'b1 || xoff_count !== 16'd1) begin
            failures++;
            $display("FAIL basic_paused got=%b/%b/%h required=0/1/0001", tvalid, paused, xoff_count);
        end
        @(negedge clk);
        above = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tvalid) hi++;
        end
        checks++;
        if (hi != 0 || paused !== 1'b1) begin
            failures++;
            $display("FAIL basic_hold got=%0d/%b required=0/1", hi, paused);
        end
        below = 1'b1; exp_q.push_back(XON_W);
        @(negedge clk);
        checks++;
        if (tvalid !== 1'b1 || tdata !== XON_W || paused !== 1'b1) begin
            failures++;
            $display("FAIL basic_xon got=%b/%h/%b required=1/0000/1", tvalid, tdata, paused);
        end
        @(negedge clk);
        checks++;
        if (tvalid !== 1'b0 || paused !== 1'b0 || xoff_count !== 16'd1) begin
            failures++;
            $display("FAIL basic_resumed got=%b/%b/%h required=0/0/0001", tvalid, paused, xoff_count);
        end
        below = 1'b0;
    endtask

    task automatic test_backpressure;
        tready = 1'b0; above = 1'b1; exp_q.push_back(XOFF_W);
        @(negedge clk);
        above = 1'b0; below = 1'b1; exp_q.push_back(XON_W);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (tvalid !== 1'b1 || tdata !== XOFF_W) begin
                failures++;
                $display("FAIL bp_stable cyc=%0d got=%b/%h required=1/ff01", i, tvalid, tdata);
            end
            @(negedge clk);
        end
        tready = 1'b1;
        @(negedge clk);
        checks++;
        if (tvalid !== 1'b0 || paused !== 1'b1 || xoff_count !== 16'd2) begin
            failures++;
            $display("FAIL bp_paused got=%b/%b/%h required=0/1/0002", tvalid, paused, xoff_count);
        end
        @(negedge clk);
        checks++;
        if (tvalid !== 1'b1 || tdata !== XON_W) begin
            failures++;
            $display("FAIL bp_xon got=%b/%h required=1/0000", tvalid, tdata);
        end
        @(negedge clk);
        below = 1'b0;
        checks++;
        if (paused !== 1'b0 || tvalid !== 1'b0) begin
            failures++;
            $display("FAIL bp_resumed got=%b/%b required=0/0", paused, tvalid);
        end
    endtask

    task automatic test_ready_loss;
        above = 1'b1; exp_q.push_back(XOFF_W);
        repeat (2) @(negedge clk);
        checks++;
        if (paused !== 1'b1) begin
            failures++;
            $display("FAIL rl_paused got=%b required=1", paused);
        end
        ready = 1'b0; exp_q.push_back(XON_W);
        @(negedge clk);
        checks++;
        if (tvalid !== 1'b1 || tdata !== XON_W) begin
            failures++;
            $display("FAIL rl_xon got=%b/%h required=1/0000", tvalid, tdata);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (tvalid !== 1'b0 || paused !== 1'b0) begin
                failures++;
                $display("FAIL rl_no_xoff cyc=%0d got=%b/%b required=0/0", i, tvalid, paused);
            end
        end
        above = 1'b0; ready = 1'b1;
    endtask

    task automatic test_reset_mid;
        above = 1'b1; exp_q.push_back(XOFF_W);
        repeat (2) @(negedge clk);
        above = 1'b0; below = 1'b1; tready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (tvalid !== 1'b1 || tdata !== XON_W || paused !== 1'b1) begin
            failures++;
            $display("FAIL rm_stalled got=%b/%h/%b required=1/0000/1", tvalid, tdata, paused);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({tvalid, tdata, paused, xoff_count} !== 34'd0) begin
            failures++;
            $display("FAIL rm_reset got=%b/%h/%b/%h required=0/0000/0/0000", tvalid, tdata, paused, xoff_count);
        end
        rst = 1'b0; below = 1'b0; tready = 1'b1;
    endtask

    task automatic test_back_to_back;
        above = 1'b1; exp_q.push_back(XOFF_W);
        repeat (2) @(negedge clk);
        below = 1'b1; tready = 1'b0; exp_q.push_back(XON_W);
        @(negedge clk);
        checks++;
        if (tvalid !== 1'b1 || tdata !== XON_W) begin
            failures++;
            $display("FAIL b2b_both_flags got=%b/%h required=1/0000", tvalid, tdata);
        end
        below = 1'b0; tready = 1'b1; exp_q.push_back(XOFF_W);
        @(negedge clk);
        checks++;
        if (tvalid !== 1'b0 || paused !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap got=%b/%b required=0/0", tvalid, paused);
        end
        @(negedge clk);
        checks++;
        if (tvalid !== 1'b1 || tdata !== XOFF_W) begin
            failures++;
            $display("FAIL b2b_reissue got=%b/%h required=1/ff01", tvalid, tdata);
        end
        @(negedge clk);
        above = 1'b0; below = 1'b1; exp_q.push_back(XON_W);
        repeat (2) @(negedge clk);
        below = 1'b0;
        checks++;
        if (paused !== 1'b0 || xoff_count !== 16'd2) begin
            failures++;
            $display("FAIL b2b_count got=%b/%h required=0/0002", paused, xoff_count);
        end
    endtask

    task automatic test_refresh;
        int np = 0;
        r_ready = 1'b1; r_tready = 1'b1; r_above = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (r_tvalid) begin
                checks++;
                if (i != 1 + 6 * np || r_tdata !== XOFF_W) begin
                    failures++;
                    $display("FAIL ref_spacing got=cyc%0d/%h required=cyc%0d/ff01", i, r_tdata, 1 + 6 * np);
                end
                np++;
            end
        end
        checks++;
        if (np != 7 || r_xoff_count !== 16'd7 || r_paused !== 1'b1) begin
            failures++;
            $display("FAIL ref_count got=%0d/%h/%b required=7/0007/1", np, r_xoff_count, r_paused);
        end
        r_above = 1'b0; r_below = 1'b1;
        @(negedge clk);
        checks++;
        if (r_tvalid !== 1'b1 || r_tdata !== XON_W) begin
            failures++;
            $display("FAIL ref_xon got=%b/%h required=1/0000", r_tvalid, r_tdata);
        end
        @(negedge clk);
        checks++;
        if (r_paused !== 1'b0 || r_xoff_count !== 16'd7) begin
            failures++;
            $display("FAIL ref_resumed got=%b/%h required=0/0007", r_paused, r_xoff_count);
        end
        r_below = 1'b0;
    endtask

    task automatic test_saturation;
        int  n = 0;
        bit  done = 1'b0;
        logic [15:0] e;
        while (!done && n < 300000) begin
            @(negedge clk_s);
            n++;
            if (s_hs == 100 || s_hs >= 65530) begin
                e = (s_hs > 65535) ? 16'hFFFF : 16'(s_hs);
                checks++;
                if (s_xoff_count !== e) begin
                    failures++;
                    $display("FAIL sat_count hs=%0d got=%h required=%h", s_hs, s_xoff_count, e);
                end
                checks++;
                if (s_tvalid ? (s_tdata !== XOFF_W) : (s_paused !== 1'b1)) begin
                    failures++;
                    $display("FAIL sat_cycle got=%b/%h/%b required=ff01 or paused", s_tvalid, s_tdata, s_paused);
                end
            end
            if (s_hs >= 65540) done = 1'b1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL sat_timeout got=%0d required=65540", s_hs);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_ready_loss();
        test_reset_mid();
        test_back_to_back();
        test_refresh();
        test_saturation();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
